ts_ordered_set_detector: RTL and testbench
==========================================

TS_ORDERED_SET_DETECTOR -- requirements
Module: ts_ordered_set_detector

Interface
REQ-001 SHALL have parameter CTR_W, default 16, ordered-set counter width.
REQ-002 SHALL have parameter COM_SYM, default 8'hBC, K28.5 comma value.
REQ-003 SHALL have parameter PAD_SYM, default 8'hF7, K23.7 PAD value.
REQ-004 SHALL have port clk  input  1  single clock for all logic, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en_n  input  1  lane transmitter electrical idle; high = no symbols.
REQ-007 SHALL have port txdata  input  8  per-lane symbol from MAC, one per clk.
REQ-008 SHALL have port txdatak  input  1  high = txdata is a K symbol.
REQ-009 SHALL have port ts1ctr  output  CTR_W  consecutive matching TS1 count, saturating.
REQ-010 SHALL have port ts2ctr  output  CTR_W  consecutive matching TS2 count, saturating.
REQ-011 SHALL have port os_valid  output  1  one-cycle pulse on each well-formed TS1/TS2.
REQ-012 SHALL have port os_is_ts2  output  1  type of last valid OS (0 = TS1, 1 = TS2).
REQ-013 SHALL have port link_num, lane_num, n_fts, rate_id, train_ctrl  output  8 each  symbols 1-5 of last valid OS.
REQ-014 SHALL have port os_err  output  1  one-cycle pulse on each malformed or aborted OS.

Function
REQ-015 SHALL implement FSM states IDLE, HDR (symbols 1-5), ID (symbols 6-15); sym_idx 4-bit index 1..15.
REQ-016 IDLE: on en_n=0, txdatak=1, txdata=COM_SYM -> HDR, sym_idx=1; all other symbols ignored, no os_err.
REQ-017 HDR symbol 1,2: accept PAD_SYM with k=1 or any D symbol (k=0); symbols 3,4,5 SHALL require k=0.
REQ-018 HDR symbol 4 (rate_id): bit 1 SHALL be 1 (2.5 GT/s supported), else malformed.
REQ-019 ID symbol 6 SHALL be k=0 and 8'h4A (TS1) or 8'h45 (TS2); that value fixes the OS type.
REQ-020 ID symbols 7-15 SHALL be k=0 and equal to symbol 6; any mismatch is malformed.
REQ-021 After symbol 15 accepted: os_valid=1 on the next rising edge (latency 1 clk), captured fields and os_is_ts2 updated that same edge, FSM -> IDLE.
REQ-022 Back-to-back OS (COM in the cycle after symbol 15) SHALL be detected with no gap cycle.
REQ-023 Valid TS1: ts1ctr += 1, ts2ctr <= 0; valid TS2: ts2ctr += 1, ts1ctr <= 0.
REQ-024 If link_num or lane_num differ from the previously captured values, the incremented counter SHALL restart at 1 instead of incrementing.
REQ-025 Counters SHALL saturate at 2^CTR_W-1; no wrap to 0.
REQ-026 Malformed symbol: os_err pulses next edge, ts1ctr and ts2ctr <= 0, captured fields hold, FSM -> IDLE.
REQ-027 COM received in HDR or ID: counts as malformed (os_err, counters cleared) and SHALL restart at HDR, sym_idx=1, same edge.
REQ-028 en_n rising mid-OS: partial OS discarded, FSM -> IDLE, no os_err, counters hold.
REQ-029 en_n=1 in IDLE: counters and fields hold indefinitely.
REQ-030 os_valid and os_err SHALL never assert in the same cycle.

Reset
REQ-031 reset=1 sampled at clk edge: FSM IDLE, sym_idx 0, ts1ctr/ts2ctr 0, os_valid/os_err 0, os_is_ts2 0, link_num/lane_num PAD_SYM, n_fts/rate_id/train_ctrl 0.
REQ-032 reset SHALL dominate all other inputs, including mid-OS; no os_err or os_valid is generated by reset.
REQ-033 No output SHALL change asynchronously to clk.

Verification
REQ-034 16 back-to-back TS1 (COM, PAD, PAD, 0x00, 0x02, 0x00, 10x 0x4A) -> os_valid 16 pulses, ts1ctr=16, ts2ctr=0, os_is_ts2=0.
REQ-035 8 TS1 then 4 TS2 (ID 0x45) -> after first TS2 ts1ctr=0, ts2ctr=1; final ts2ctr=4.
REQ-036 TS1 with symbol 11 = 0x45 -> os_err one pulse, both counters 0; next good TS1 -> ts1ctr=1.
REQ-037 3 TS1 link_num=0x00, then TS1 link_num=0x01 -> ts1ctr=1, link_num=0x01.
REQ-038 en_n high at symbol 8, then low and 2 good TS1 -> no os_err, ts1ctr=prior+2; COM at symbol 9 -> os_err, restart, next 15 symbols form valid OS.
REQ-039 CTR_W=4, 20 TS1 -> ts1ctr=15 held; reset asserted at symbol 7 -> all outputs at REQ-031 values next edge.

Source files
------------

// File: rtl/ts_ordered_set_detector.sv
// Per-lane TS1/TS2 training ordered-set detector.
// Validates COM + 15 symbols, captures header fields and keeps saturating consecutive-match counters.
module ts_ordered_set_detector #(
    parameter int          CTR_W   = 16,
    parameter logic [7:0]  COM_SYM = 8'hBC,
    parameter logic [7:0]  PAD_SYM = 8'hF7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_n,
    input  logic [7:0]       txdata,
    input  logic             txdatak,
    output logic [CTR_W-1:0] ts1ctr,
    output logic [CTR_W-1:0] ts2ctr,
    output logic             os_valid,
    output logic             os_is_ts2,
    output logic [7:0]       link_num,
    output logic [7:0]       lane_num,
    output logic [7:0]       n_fts,
    output logic [7:0]       rate_id,
    output logic [7:0]       train_ctrl,
    output logic             os_err
);

    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;

    typedef enum logic [1:0] {IDLE, HDR, ID} state_t;

    state_t     state, state_nx;
    logic [3:0] sym_idx, idx_nx;
    logic       is_com, sym_ok, os_done, os_bad, same_id;
    logic [7:0] sh_link, sh_lane, sh_nfts, sh_rate, sh_ctrl, id_sym;

    assign is_com  = txdatak && (txdata == COM_SYM);
    assign same_id = (sh_link == link_num) && (sh_lane == lane_num);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sym_idx <= '0;
        end else begin
            state   <= state_nx;
            sym_idx <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = sym_idx;
        sym_ok   = 1'b0;
        os_done  = 1'b0;
        os_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (!en_n && is_com) begin
                    state_nx = HDR;
                    idx_nx   = 4'd1;
                end
            end
            default: begin
                if (en_n) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else if (is_com) begin
                    // A COM inside an OS is both an error and the start of the next OS
                    os_bad   = 1'b1;
                    state_nx = HDR;
                    idx_nx   = 4'd1;
                end else begin
                    if (state == HDR) begin
                        case (sym_idx)
                            4'd1, 4'd2: sym_ok = !txdatak || (txdata == PAD_SYM);
                            4'd4:       sym_ok = !txdatak && txdata[1];
                            default:    sym_ok = !txdatak;
                        endcase
                    end else if (sym_idx == 4'd6) begin
                        sym_ok = !txdatak && ((txdata == TS1_ID) || (txdata == TS2_ID));
                    end else begin
                        sym_ok = !txdatak && (txdata == id_sym);
                    end

                    if (!sym_ok) begin
                        os_bad   = 1'b1;
                        state_nx = IDLE;
                        idx_nx   = '0;
                    end else if (sym_idx == 4'd15) begin
                        os_done  = 1'b1;
                        state_nx = IDLE;
                        idx_nx   = '0;
                    end else begin
                        idx_nx   = sym_idx + 4'd1;
                        state_nx = (sym_idx == 4'd5) ? ID : state;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts1ctr     <= '0;
            ts2ctr     <= '0;
            os_valid   <= 1'b0;
            os_err     <= 1'b0;
            os_is_ts2  <= 1'b0;
            link_num   <= PAD_SYM;
            lane_num   <= PAD_SYM;
            n_fts      <= '0;
            rate_id    <= '0;
            train_ctrl <= '0;
            sh_link    <= PAD_SYM;
            sh_lane    <= PAD_SYM;
            sh_nfts    <= '0;
            sh_rate    <= '0;
            sh_ctrl    <= '0;
            id_sym     <= '0;
        end else begin
            os_valid <= os_done;
            os_err   <= os_bad;

            // Header symbols go to shadow copies; outputs only change on a complete OS
            if (sym_ok) begin
                case (sym_idx)
                    4'd1:    sh_link <= txdata;
                    4'd2:    sh_lane <= txdata;
                    4'd3:    sh_nfts <= txdata;
                    4'd4:    sh_rate <= txdata;
                    4'd5:    sh_ctrl <= txdata;
                    4'd6:    id_sym  <= txdata;
                    default: ;
                endcase
            end

            if (os_done) begin
                link_num   <= sh_link;
                lane_num   <= sh_lane;
                n_fts      <= sh_nfts;
                rate_id    <= sh_rate;
                train_ctrl <= sh_ctrl;
                os_is_ts2  <= (id_sym == TS2_ID);
                if (id_sym == TS2_ID) begin
                    ts1ctr <= '0;
                    if (!same_id)          ts2ctr <= CTR_W'(1);
                    else if (ts2ctr != '1) ts2ctr <= ts2ctr + 1'b1;
                end else begin
                    ts2ctr <= '0;
                    if (!same_id)          ts1ctr <= CTR_W'(1);
                    else if (ts1ctr != '1) ts1ctr <= ts1ctr + 1'b1;
                end
            end else if (os_bad) begin
                ts1ctr <= '0;
                ts2ctr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ts_ordered_set_detector.sv
// Directed table-driven bench for ts_ordered_set_detector: a default-width instance plus a
// CTR_W=4 instance sharing the symbol stream but with its own reset.
module tb_ts_ordered_set_detector;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] PAD = 8'hF7;
    localparam logic [7:0] T1  = 8'h4A;
    localparam logic [7:0] T2  = 8'h45;

    logic        clk = 1'b0;
    logic        reset, reset_s, en_n, txdatak;
    logic [7:0]  txdata;

    logic [15:0] ts1ctr, ts2ctr;
    logic        os_valid, os_is_ts2, os_err;
    logic [7:0]  link_num, lane_num, n_fts, rate_id, train_ctrl;

    logic [3:0]  s_ts1ctr, s_ts2ctr;
    logic        s_os_valid, s_os_is_ts2, s_os_err;
    logic [7:0]  s_link_num, s_lane_num, s_n_fts, s_rate_id, s_train_ctrl;

    ts_ordered_set_detector #(.CTR_W(16), .COM_SYM(COM), .PAD_SYM(PAD)) dut (
        .clk(clk), .reset(reset), .en_n(en_n), .txdata(txdata), .txdatak(txdatak),
        .ts1ctr(ts1ctr), .ts2ctr(ts2ctr), .os_valid(os_valid), .os_is_ts2(os_is_ts2),
        .link_num(link_num), .lane_num(lane_num), .n_fts(n_fts), .rate_id(rate_id),
        .train_ctrl(train_ctrl), .os_err(os_err)
    );

    ts_ordered_set_detector #(.CTR_W(4), .COM_SYM(COM), .PAD_SYM(PAD)) dut_s (
        .clk(clk), .reset(reset_s), .en_n(en_n), .txdata(txdata), .txdatak(txdatak),
        .ts1ctr(s_ts1ctr), .ts2ctr(s_ts2ctr), .os_valid(s_os_valid), .os_is_ts2(s_os_is_ts2),
        .link_num(s_link_num), .lane_num(s_lane_num), .n_fts(s_n_fts), .rate_id(s_rate_id),
        .train_ctrl(s_train_ctrl), .os_err(s_os_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int nvalid, nerr, s_nvalid, s_nerr, overlap;

    typedef struct {
        logic [7:0]  link, lane, id;
        int          bad_idx;
        logic        bad_k;
        logic [7:0]  bad_val;
        int          exp_valid, exp_err;
        logic [15:0] exp_ts1, exp_ts2;
        logic        exp_is_ts2;
        logic [7:0]  exp_link;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] link, lane, id, input int bad_idx,
                                input logic bad_k, input logic [7:0] bad_val,
                                input int ev, ee, input logic [15:0] e1, e2,
                                input logic ets2, input logic [7:0] elink);
        vec_t v;
        v.link = link; v.lane = lane; v.id = id;
        v.bad_idx = bad_idx; v.bad_k = bad_k; v.bad_val = bad_val;
        v.exp_valid = ev; v.exp_err = ee; v.exp_ts1 = e1; v.exp_ts2 = e2;
        v.exp_is_ts2 = ets2; v.exp_link = elink;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic put(input logic e, input logic k, input logic [7:0] d);
        en_n = e; txdatak = k; txdata = d;
        @(posedge clk);
        #1;
        if (os_valid) nvalid++;
        if (os_err) nerr++;
        if (s_os_valid) s_nvalid++;
        if (s_os_err) s_nerr++;
        if ((os_valid && os_err) || (s_os_valid && s_os_err)) overlap++;
    endtask

    // Symbol idx of a well-formed OS: returns {k, data}
    function automatic logic [8:0] os_sym(input int idx, input logic [7:0] link, lane, id);
        case (idx)
            0:       return {1'b1, COM};
            1:       return (link == PAD) ? {1'b1, PAD} : {1'b0, link};
            2:       return (lane == PAD) ? {1'b1, PAD} : {1'b0, lane};
            3:       return {1'b0, 8'h00};
            4:       return {1'b0, 8'h02};
            5:       return {1'b0, 8'h00};
            default: return {1'b0, id};
        endcase
    endfunction

    task automatic send_range(input logic [7:0] link, lane, id, input int from, input int to);
        logic [8:0] s;
        for (int i = from; i <= to; i++) begin
            s = os_sym(i, link, lane, id);
            put(1'b0, s[8], s[7:0]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] s;
        nvalid = 0; nerr = 0; s_nvalid = 0; s_nerr = 0; overlap = 0;

        for (int i = 1; i <= 16; i++) tbl.push_back(mk(PAD, PAD, T1, -1, 1'b0, 8'h00, 1, 0, 16'(i), 0, 1'b0, PAD));
        for (int j = 1; j <= 4; j++)  tbl.push_back(mk(PAD, PAD, T2, -1, 1'b0, 8'h00, 1, 0, 0, 16'(j), 1'b1, PAD));
        tbl.push_back(mk(PAD,   PAD, T1, 11, 1'b0, T2,    0, 1, 0, 0, 1'b1, PAD));
        tbl.push_back(mk(PAD,   PAD, T1, -1, 1'b0, 8'h00, 1, 0, 1, 0, 1'b0, PAD));
        tbl.push_back(mk(8'h00, PAD, T1, -1, 1'b0, 8'h00, 1, 0, 1, 0, 1'b0, 8'h00));
        tbl.push_back(mk(8'h00, PAD, T1, -1, 1'b0, 8'h00, 1, 0, 2, 0, 1'b0, 8'h00));
        tbl.push_back(mk(8'h00, PAD, T1, -1, 1'b0, 8'h00, 1, 0, 3, 0, 1'b0, 8'h00));
        tbl.push_back(mk(8'h01, PAD, T1, -1, 1'b0, 8'h00, 1, 0, 1, 0, 1'b0, 8'h01));
        tbl.push_back(mk(8'h01, PAD, T1,  4, 1'b0, 8'h00, 0, 1, 0, 0, 1'b0, 8'h01));
        tbl.push_back(mk(8'h01, PAD, T1,  3, 1'b1, 8'h00, 0, 1, 0, 0, 1'b0, 8'h01));
        tbl.push_back(mk(8'h01, PAD, T1,  6, 1'b0, 8'h4B, 0, 1, 0, 0, 1'b0, 8'h01));
        tbl.push_back(mk(8'h01, PAD, T1,  9, 1'b1, T1,    0, 1, 0, 0, 1'b0, 8'h01));
        tbl.push_back(mk(8'h01, PAD, T1, -1, 1'b0, 8'h00, 1, 0, 1, 0, 1'b0, 8'h01));
        tbl.push_back(mk(8'h01, PAD, T1, -1, 1'b0, 8'h00, 1, 0, 2, 0, 1'b0, 8'h01));

        // Reset state
        reset = 1'b1; reset_s = 1'b1;
        put(1'b1, 1'b0, 8'h00);
        put(1'b0, 1'b1, COM);
        reset = 1'b0; reset_s = 1'b0;
        chk("rst_ts1ctr", ts1ctr, 0);
        chk("rst_ts2ctr", ts2ctr, 0);
        chk("rst_valid", os_valid, 0);
        chk("rst_err", os_err, 0);
        chk("rst_is_ts2", os_is_ts2, 0);
        chk("rst_link", link_num, PAD);
        chk("rst_lane", lane_num, PAD);
        chk("rst_nfts", n_fts, 0);
        chk("rst_rate", rate_id, 0);
        chk("rst_ctrl", train_ctrl, 0);

        // Non-COM traffic in IDLE and COM under electrical idle are ignored
        nvalid = 0; nerr = 0;
        put(1'b0, 1'b0, T1); put(1'b0, 1'b1, PAD); put(1'b0, 1'b0, 8'h02);
        put(1'b1, 1'b1, COM); put(1'b1, 1'b0, 8'h00);
        chk("idle_err", nerr, 0);
        chk("idle_valid", nvalid, 0);
        chk("idle_ts1ctr", ts1ctr, 0);

        foreach (tbl[i]) begin
            nvalid = 0; nerr = 0;
            for (int idx = 0; idx <= 15; idx++) begin
                s = os_sym(idx, tbl[i].link, tbl[i].lane, tbl[i].id);
                if (idx == tbl[i].bad_idx) s = {tbl[i].bad_k, tbl[i].bad_val};
                put(1'b0, s[8], s[7:0]);
            end
            chk($sformatf("v%0d_valid", i), nvalid, tbl[i].exp_valid);
            chk($sformatf("v%0d_err", i), nerr, tbl[i].exp_err);
            chk($sformatf("v%0d_ts1ctr", i), ts1ctr, tbl[i].exp_ts1);
            chk($sformatf("v%0d_ts2ctr", i), ts2ctr, tbl[i].exp_ts2);
            chk($sformatf("v%0d_is_ts2", i), os_is_ts2, tbl[i].exp_is_ts2);
            chk($sformatf("v%0d_link", i), link_num, tbl[i].exp_link);
        end
        chk("fld_lane", lane_num, PAD);
        chk("fld_nfts", n_fts, 8'h00);
        chk("fld_rate", rate_id, 8'h02);
        chk("fld_ctrl", train_ctrl, 8'h00);

        // Electrical idle at symbol 8 drops the partial OS silently
        nvalid = 0; nerr = 0;
        send_range(8'h01, PAD, T1, 0, 7);
        put(1'b1, 1'b0, T1); put(1'b1, 1'b0, T1); put(1'b1, 1'b1, COM);
        chk("eidle_err", nerr, 0);
        chk("eidle_valid", nvalid, 0);
        chk("eidle_ts1ctr", ts1ctr, 2);
        send_range(8'h01, PAD, T1, 0, 15);
        send_range(8'h01, PAD, T1, 0, 15);
        chk("eidle_after_ts1ctr", ts1ctr, 4);
        chk("eidle_after_valid", nvalid, 2);
        chk("eidle_after_err", nerr, 0);

        // COM at symbol 9: error, then the same COM starts a valid OS
        nvalid = 0; nerr = 0;
        send_range(8'h01, PAD, T1, 0, 8);
        put(1'b0, 1'b1, COM);
        chk("com9_err", nerr, 1);
        chk("com9_ts1ctr", ts1ctr, 0);
        send_range(8'h01, PAD, T1, 1, 15);
        chk("com9_restart_valid", nvalid, 1);
        chk("com9_restart_err", nerr, 1);
        chk("com9_restart_ts1ctr", ts1ctr, 1);

        // Saturation on the 4-bit instance
        reset_s = 1'b1;
        put(1'b0, 1'b0, 8'h00);
        reset_s = 1'b0;
        s_nvalid = 0; s_nerr = 0;
        for (int n = 0; n < 20; n++) send_range(PAD, PAD, T1, 0, 15);
        chk("sat_ts1ctr", s_ts1ctr, 4'hF);
        chk("sat_valid", s_nvalid, 20);
        chk("sat_main_ts1ctr", ts1ctr, 20);

        // Reset at symbol 7 of the 4-bit instance
        send_range(PAD, PAD, T1, 0, 6);
        reset_s = 1'b1;
        put(1'b0, 1'b0, T1);
        reset_s = 1'b0;
        chk("mid_rst_ts1ctr", s_ts1ctr, 0);
        chk("mid_rst_ts2ctr", s_ts2ctr, 0);
        chk("mid_rst_valid", s_os_valid, 0);
        chk("mid_rst_err", s_os_err, 0);
        chk("mid_rst_is_ts2", s_os_is_ts2, 0);
        chk("mid_rst_link", s_link_num, PAD);
        chk("mid_rst_lane", s_lane_num, PAD);
        chk("mid_rst_nfts", s_n_fts, 0);
        chk("mid_rst_rate", s_rate_id, 0);
        chk("mid_rst_ctrl", s_train_ctrl, 0);
        send_range(PAD, PAD, T1, 8, 15);
        chk("mid_rst_tail_valid", s_nvalid, 20);
        chk("mid_rst_tail_err", s_nerr, 0);
        chk("mid_rst_main_ts1ctr", ts1ctr, 21);

        chk("valid_err_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
